// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared states, default endpoint addresses, flag/strobe polarities and clog2 for the FX2 FIFO bridge
package usb_fifo_pkg;
  typedef enum logic [2:0] {IDLE, RX_SETUP, RX_WORD, TX_SETUP, TX_WORD, TX_PKTEND, TURN} state_t;
  localparam logic [1:0] DEF_RX_ADDR = 2'b00;
  localparam logic [1:0] DEF_TX_ADDR = 2'b10;
  localparam logic FLAG_ON = 1'b0;
  localparam logic STB_ON = 1'b0;
  localparam logic PTR_RX = 1'b0;
  localparam logic PTR_TX = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/usb_strobe_timer.sv
// usb_strobe_timer: TS_NUM word-period counter; run enables, hold freezes, start/last flag counts 0 and TS_NUM-1
module usb_strobe_timer #(
  parameter int TS_NUM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic start,
  output logic last
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst || !run) cnt <= '0;
    else if (!hold) cnt <= last ? '0 : cnt + 8'd1;
  assign start = cnt == 8'd0;
  assign last = cnt == 8'(TS_NUM - 1);
endmodule

// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge: FX2 slave-FIFO controller; FX2 flags/strobes/data pins <-> rx valid/ready stream and tx valid/ready/last stream, busy when not idle
module usb_fifo_bridge import usb_fifo_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int TS_NUM = 4,
  parameter int BURST_MAX = 256,
  parameter logic [1:0] RX_ADDR = DEF_RX_ADDR,
  parameter logic [1:0] TX_ADDR = DEF_TX_ADDR,
  parameter int PKTEND_IDLE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usb_n_ept_rx,
  input  logic              usb_n_ful_tx,
  input  logic [DATA_W-1:0] usb_data_i,
  output logic [DATA_W-1:0] usb_data_o,
  output logic              usb_data_oe,
  output logic              usb_slcs,
  output logic              usb_sloe,
  output logic              usb_slrd,
  output logic              usb_slwr,
  output logic              usb_pktend,
  output logic [1:0]        usb_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
);
  localparam int IW = clog2(PKTEND_IDLE + 2);
  state_t state, nxt;
  logic ptr, pend_q, last_q, start, last, hold;
  logic rx_has, tx_has, rx_pend, tx_pend, rx_word, tx_word, tx_side, tx_acc, strobe, burst_end, timeout;
  logic [10:0] burst;
  logic [IW-1:0] idle_cnt;
  usb_strobe_timer #(.TS_NUM(TS_NUM)) u_tmr (
    .clk(clk), .rst(rst), .run(rx_word || tx_word), .hold(hold), .start(start), .last(last)
  );
  assign rx_has = usb_n_ept_rx != FLAG_ON;
  assign tx_has = usb_n_ful_tx != FLAG_ON;
  assign rx_pend = rx_has && !rx_valid;
  assign tx_pend = tx_has && tx_valid;
  assign rx_word = state == RX_WORD;
  assign tx_word = state == TX_WORD;
  assign tx_side = state == TX_SETUP || tx_word || state == TX_PKTEND;
  assign tx_acc = tx_word && start && tx_valid && tx_has;
  assign strobe = (rx_word || tx_word) && last;
  assign burst_end = 12'(burst) >= 12'(BURST_MAX - 1);
  assign timeout = PKTEND_IDLE > 0 && pend_q && idle_cnt == IW'(PKTEND_IDLE - 1);
  assign hold = start && (rx_word ? (rx_valid && !rx_ready) || !rx_has : !tx_acc);
  assign tx_ready = tx_acc;
  assign usb_slcs = STB_ON;
  assign usb_sloe = !(state == RX_SETUP || rx_word);
  assign usb_slrd = !(rx_word && last);
  assign usb_slwr = !(tx_word && last);
  assign usb_pktend = state != TX_PKTEND;
  assign usb_addr = tx_side ? TX_ADDR : RX_ADDR;
  assign usb_data_oe = tx_side;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = rx_pend && (!tx_pend || ptr == PTR_RX) ? RX_SETUP : tx_pend ? TX_SETUP : timeout ? TX_PKTEND : IDLE;
      RX_SETUP:  nxt = RX_WORD;
      RX_WORD:   nxt = (start && !rx_has) || (last && (!rx_has || burst_end || (tx_pend && ptr == PTR_TX))) ? IDLE : RX_WORD;
      TX_SETUP:  nxt = TX_WORD;
      TX_WORD:   nxt = start && !tx_acc ? TURN : !last ? TX_WORD : last_q ? TX_PKTEND :
                       (!tx_has || burst_end || !tx_valid || (rx_pend && ptr == PTR_RX)) ? TURN : TX_WORD;
      TX_PKTEND: nxt = TURN;
      TURN:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= PTR_RX;
      pend_q <= 1'b0;
      last_q <= 1'b0;
      burst <= '0;
      idle_cnt <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      usb_data_o <= '0;
    end else begin
      state <= nxt;
      if (rx_word && nxt == IDLE) ptr <= PTR_TX;
      else if (tx_word && nxt != TX_WORD) ptr <= PTR_RX;
      pend_q <= state == TX_PKTEND ? 1'b0 : (tx_word && last) ? 1'b1 : pend_q;
      burst <= (state == RX_SETUP || state == TX_SETUP) ? '0 : (strobe && 12'(burst) < 12'(BURST_MAX)) ? burst + 11'd1 : burst;
      idle_cnt <= (state == IDLE && nxt == IDLE) ? idle_cnt + 1'b1 : '0;
      if (rx_word && last) begin
        rx_data <= usb_data_i;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
      if (tx_acc) begin
        usb_data_o <= tx_data;
        last_q <= tx_last;
      end
    end
endmodule

// File: doc/usb_fifo_bridge.md
Name: usb_fifo_bridge

Overview:
- Generalised controller for a Cypress FX2-style synchronous slave FIFO. Bidirectional: OUT endpoint words go to a valid/ready RX stream; a valid/ready TX stream with a last flag goes to the IN endpoint.
- Over the fixed loopback/auto-test controller it adds parametrised width, strobe timing, endpoint addresses and burst length.
- New behaviour: back-pressure-aware reads, round-robin RX/TX arbitration with bus turnaround, and PKTEND generation for short packets.
- Sits between the FX2 pins and the FPGA datapath; tri-state is resolved in the top level.

Parameters:
- DATA_W, 16, FIFO bus width; legal values are 8 and 16.
- TS_NUM, 4, clocks per word transfer; must be at least 2.
- BURST_MAX, 256, maximum words per grant before re-arbitration; range 1..2048.
- RX_ADDR, 2'b00, FIFOADR for the OUT endpoint (EP2).
- TX_ADDR, 2'b10, FIFOADR for the IN endpoint (EP6).
- PKTEND_IDLE, 64, idle clocks after a TX word before a forced PKTEND; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- usb_n_ept_rx  in  1  OUT FIFO empty flag, active low
- usb_n_ful_tx  in  1  IN FIFO full flag, active low
- usb_data_i  in  DATA_W  FIFO data from pins
- usb_data_o  out  DATA_W  FIFO data to pins
- usb_data_oe  out  1  pin driver enable, 1 = drive
- usb_slcs  out  1  chip select, active low
- usb_sloe  out  1  output enable, active low
- usb_slrd  out  1  read strobe, active low
- usb_slwr  out  1  write strobe, active low
- usb_pktend  out  1  packet end, active low
- usb_addr  out  2  FIFOADR
- rx_data  out  DATA_W  received word
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  sink accepts rx_data
- tx_data  in  DATA_W  word to send
- tx_last  in  1  last word of packet
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle accept pulse
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - usb_slcs=0, usb_sloe=1, usb_slrd=1, usb_slwr=1, usb_pktend=1.
  - usb_addr=RX_ADDR, usb_data_oe=0, usb_data_o=0.
  - rx_valid=0, rx_data=0, tx_ready=0, busy=0.
  - state=IDLE, word and burst counters 0, round-robin pointer points to RX.
  - A reset mid-transfer takes effect at the next edge and drops any in-flight word.
- States: IDLE, RX_SETUP, RX_WORD, TX_SETUP, TX_WORD, TX_PKTEND, TURN.
- IDLE: RX is pending when usb_n_ept_rx=1 and rx_valid=0. TX is pending when usb_n_ful_tx=1 and tx_valid=1. If both are pending, the round-robin pointer picks; the winner sets the pointer to the other side. Idle timeout may go to TX_PKTEND (see PKTEND rule).
- RX_SETUP: one cycle. usb_addr=RX_ADDR, usb_sloe=0.
- RX_WORD:
  - The cycle counter runs 0..TS_NUM-1, and usb_slrd=0 only at count TS_NUM-1.
  - On that edge, usb_data_i is captured into rx_data and rx_valid=1 the next cycle. Latency from SLRD low to rx_valid is 1 clock.
  - rx_valid clears on rx_valid && rx_ready.
  - The next word's counter holds at 0 while rx_valid && !rx_ready, and no strobe is issued.
- RX burst end: after the strobe, exit to IDLE if usb_n_ept_rx=0, the burst count reaches BURST_MAX, or TX is pending and the pointer is TX. On exit usb_sloe=1.
- TX_SETUP: one cycle. usb_addr=TX_ADDR, usb_data_oe=1.
- TX_WORD:
  - At count 0, if tx_valid && usb_n_ful_tx: tx_ready=1 for that cycle and tx_data is latched to usb_data_o.
  - usb_slwr=0 only at count TS_NUM-1.
  - Data stays stable for the whole word period.
- TX burst end: after the strobe, a word with tx_last goes to TX_PKTEND. Otherwise the burst ends on full, the BURST_MAX limit, tx_valid=0, or a pending RX with the pointer at RX.
- TX_PKTEND: usb_pktend=0 for exactly 1 clock with usb_addr=TX_ADDR, then TURN. It is never asserted in the same cycle as usb_slwr=0.
- PKTEND timeout: if PKTEND_IDLE>0 and at least one TX word has been written since the last PKTEND, PKTEND_IDLE clocks in IDLE without TX activity go to TX_PKTEND.
- TURN: one cycle with all strobes high and usb_data_oe=0. It is inserted on every exit from TX toward IDLE, so the bus is never driven while usb_sloe=0.
- Counters: the word counter is 8 bits; the burst counter is 11 bits and saturates at BURST_MAX.
- Flag precedence: a flag change during a word is ignored until the strobe cycle. A flag deasserted at count 0 aborts the word with no strobe and no tx_ready.

Decomposition:
- Package usb_fifo_pkg:
  - state enum;
  - default RX/TX addresses;
  - flag-polarity constants;
  - function clog2.
- Sub-module usb_strobe_timer:
  - TS_NUM word-period counter with hold, start and last-cycle outputs;
  - instanced once and shared by RX and TX.

Test Plan:
- RX only, TS_NUM=4, 3 words A1,A2,A3, rx_ready=1: SLRD low every 4th clock, 3 rx_valid pulses each 1 clk after the strobe, exit when empty drops.
- RX back-pressure, rx_ready=0 for 10 clk after the first word: no second SLRD until rx_ready=1; exactly 1 strobe per accepted word, no loss.
- TX packet of 5 words with tx_last on 0x0005: 5 SLWR pulses with data stable 4 clk each, then one PKTEND low cycle, then TURN with oe=0.
- Both pending continuously, BURST_MAX=4: transfers alternate 4 RX / 4 TX with TURN after every TX burst; usb_addr 00/10 matches each grant.
- TX 2 words without tx_last, then idle, PKTEND_IDLE=64: PKTEND asserted 64 clk after returning to IDLE; full flag asserted mid-burst stops SLWR with no tx_ready.
- Reset asserted during RX_WORD at count 2: next cycle all strobes are high, rx_valid=0, oe=0, state IDLE.
